// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin burst arbiter.
package arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  localparam int ARB_DEFAULT_WEIGHT = 4;
  localparam int ARB_MAX_REQ        = 16;

  function automatic logic [ARB_MAX_REQ-1:0] idx_to_onehot(input logic [3:0] idx);
    logic [ARB_MAX_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set mask bit from ptr upward,
// with an optional index pushed to the very end of the search order.
module rr_pick #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] ptr,
  input  logic [IDX_W-1:0] last_idx,
  input  logic             last_en,
  output logic [IDX_W-1:0] sel_idx,
  output logic             found
);

  logic [N-1:0]     prim;
  logic [IDX_W-1:0] cand;

  always_comb begin
    prim    = mask;
    cand    = '0;
    sel_idx = '0;
    found   = 1'b0;
    if (last_en) prim[last_idx] = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!found && prim[cand]) begin
        sel_idx = cand;
        found   = 1'b1;
      end
    end
    // The deprioritised index wins only when nobody else wants the resource.
    if (!found && last_en && mask[last_idx]) begin
      sel_idx = last_idx;
      found   = 1'b1;
    end
  end

endmodule

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter: each owner keeps the grant for up to weight[i]
// cycles, then the grant rotates with no idle bubble.
module wrr_burst_arbiter
  import arb_pkg::*;
#(
  parameter  int NUM_REQUESTS   = 4,
  parameter  int WEIGHT_W       = 3,
  parameter  int DEFAULT_WEIGHT = ARB_DEFAULT_WEIGHT,
  localparam int IDX_W          = $clog2(NUM_REQUESTS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQUESTS-1:0] req,
  input  logic                    weight_wr_en,
  input  logic [IDX_W-1:0]        weight_wr_idx,
  input  logic [WEIGHT_W-1:0]     weight_wr_data,
  output logic [NUM_REQUESTS-1:0] grant,
  output logic                    grant_valid,
  output logic [IDX_W-1:0]        grant_idx,
  output logic                    tenure_last
);

  arb_state_t             state;
  logic [WEIGHT_W-1:0]    weight_q [NUM_REQUESTS];
  logic [WEIGHT_W-1:0]    count;
  logic [WEIGHT_W-1:0]    limit;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       next_ptr;
  logic [IDX_W-1:0]       pick_ptr;
  logic [IDX_W-1:0]       sel_idx;
  logic [NUM_REQUESTS-1:0] eligible;
  logic                   found;
  logic                   owner_req;
  logic                   at_limit;
  logic [ARB_MAX_REQ-1:0] sel_onehot;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQUESTS; i++)
      eligible[i] = req[i] && (weight_q[i] != '0);
  end

  assign next_ptr    = (int'(grant_idx) == NUM_REQUESTS - 1) ? '0 : grant_idx + IDX_W'(1);
  assign pick_ptr    = (state == ARB_GRANT) ? next_ptr : ptr;
  assign owner_req   = req[grant_idx];
  assign at_limit    = (count == limit - WEIGHT_W'(1));
  assign grant_valid = |grant;
  assign tenure_last = grant_valid & at_limit & owner_req;
  assign sel_onehot  = idx_to_onehot(4'(sel_idx));

  rr_pick #(.N(NUM_REQUESTS)) u_pick (
    .mask     (eligible),
    .ptr      (pick_ptr),
    .last_idx (grant_idx),
    .last_en  (state == ARB_GRANT),
    .sel_idx  (sel_idx),
    .found    (found)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQUESTS; i++) weight_q[i] <= WEIGHT_W'(DEFAULT_WEIGHT);
    end else if (weight_wr_en && int'(weight_wr_idx) < NUM_REQUESTS) begin
      weight_q[weight_wr_idx] <= weight_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB_IDLE;
      grant     <= '0;
      grant_idx <= '0;
      count     <= '0;
      limit     <= '0;
      ptr       <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (found) begin
            state     <= ARB_GRANT;
            grant     <= sel_onehot[NUM_REQUESTS-1:0];
            grant_idx <= sel_idx;
            count     <= '0;
            limit     <= weight_q[sel_idx];
          end
        end
        ARB_GRANT: begin
          if (owner_req && count < limit - WEIGHT_W'(1)) begin
            count <= count + WEIGHT_W'(1);
          end else begin
            // Tenure complete or released early: hand over on this edge.
            ptr <= next_ptr;
            if (found) begin
              grant     <= sel_onehot[NUM_REQUESTS-1:0];
              grant_idx <= sel_idx;
              count     <= '0;
              limit     <= weight_q[sel_idx];
            end else begin
              state     <= ARB_IDLE;
              grant     <= '0;
              grant_idx <= '0;
              count     <= '0;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
